// File: rtl/write_address_gen_pkg.sv
// Shared definitions for the line-buffer write address generator and its
// read-side companion: FSM state codes and default geometry.
package wr_addr_gen_pkg;

  // State codes are fixed so the read side and debug tooling can decode them.
  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t WRITE = 2'd1;
  localparam state_t FLUSH = 2'd2;

  localparam int DEFAULT_DEPTH  = 16;
  localparam int DEFAULT_ADDR_W = 4;
  localparam int DEFAULT_WINDOW = 9;

endpackage

// File: rtl/write_address_gen_if.sv
// Producer stream into the write address generator.
// Handshake: a word transfers on a rising clk edge iff in_valid & in_ready;
// in_last only has meaning while in_valid is high; in_ready never depends on in_valid.
interface write_address_gen_if;

  logic in_valid;
  logic in_last;
  logic in_ready;

  modport master (
    output in_valid,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/write_address_gen_mod_counter.sv
// Modulo counter: counts enabled cycles 0..MOD-1 and wraps; MOD need not be
// a power of two. Synchronous clear has priority over enable.
module mod_counter #(
  parameter int MOD = 16,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + W'(1);
      end
    end
  end

endmodule

// File: rtl/write_address_gen.sv
// Producer-side address generator for the circular line buffer: accepts a
// valid/ready stream, issues wrapping write addresses and tracks occupancy.
module write_address_gen
  import wr_addr_gen_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int WINDOW = DEFAULT_WINDOW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inner_rst,
  input  logic              start,
  write_address_gen_if.slave s,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_release,
  output logic              can_count,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              done,
  output logic              err_underflow,
  output state_t            state_dbg
);

  localparam int OW = ADDR_W + 1;
  localparam logic [OW-1:0] DEPTH_OCC  = OW'(DEPTH);
  localparam logic [OW-1:0] WINDOW_OCC = OW'(WINDOW);

  state_t        state_q;
  state_t        state_d;
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;
  logic          clr;
  logic          occ_zero;
  logic          rel_eff;

  assign clr      = rst | inner_rst;
  assign occ_zero = (occ_q == '0);

  // A release against an empty buffer is dropped here and flagged below.
  assign rel_eff  = rd_release & ~occ_zero;

  assign full       = (occ_q == DEPTH_OCC);
  assign s.in_ready = (state_q == WRITE) & ~full;
  assign wr_en      = s.in_valid & s.in_ready;
  assign occupancy  = occ_q;
  assign state_dbg  = state_q;

  assign can_count = (occ_q >= WINDOW_OCC) | ((state_q == FLUSH) & ~occ_zero);
  assign done      = (state_q == FLUSH) & occ_zero;

  mod_counter #(
    .MOD (DEPTH),
    .W   (ADDR_W)
  ) u_wr_ptr (
    .clk   (clk),
    .clr   (clr),
    .en    (wr_en),
    .count (wr_addr)
  );

  always_comb begin
    occ_d = occ_q;
    unique case ({wr_en, rel_eff})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (wr_en & s.in_last) state_d = FLUSH;
      FLUSH:   if (occ_zero) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
    end
  end

  // Sticky until a reset; only a frame or global clear may hide an underflow.
  always_ff @(posedge clk) begin
    if (clr) begin
      err_underflow <= 1'b0;
    end else if (rd_release & occ_zero) begin
      err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_write_address_gen.sv
// Directed plus randomized bench for write_address_gen (DEPTH=16, WINDOW=9)
// against a cycle-level occupancy/pointer reference model.
module tb_write_address_gen;
  import wr_addr_gen_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int WINDOW = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              inner_rst;
  logic              start;
  logic              rd_release;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              can_count;
  logic [ADDR_W:0]   occupancy;
  logic              full;
  logic              done;
  logic              err_underflow;
  state_t            state_dbg;

  write_address_gen_if bus ();

  write_address_gen #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WINDOW (WINDOW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .inner_rst     (inner_rst),
    .start         (start),
    .s             (bus),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .rd_release    (rd_release),
    .can_count     (can_count),
    .occupancy     (occupancy),
    .full          (full),
    .done          (done),
    .err_underflow (err_underflow),
    .state_dbg     (state_dbg)
  );

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 accepting words, 2 draining after last word
  int m_phase;
  int m_occ;
  int m_ptr;
  bit m_err;
  int m_done_cnt;
  int dut_done_cnt;

  logic [ADDR_W-1:0] exp_q[$];

  int n_asserts;
  int n_fails;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Check outputs against the model, clock once, advance the model.
  task automatic step_cycle();
    bit ready, wr, rel, cc;
    #1;
    ready = (m_phase == 1) && (m_occ < DEPTH);
    wr    = ready && (bus.in_valid === 1'b1);
    cc    = (m_occ >= WINDOW) || (m_phase == 2 && m_occ > 0);
    chk("in_ready",  32'(bus.in_ready), 32'(ready));
    chk("wr_en",     32'(wr_en), 32'(wr));
    chk("wr_addr",   32'(wr_addr), 32'(m_ptr));
    chk("occupancy", 32'(occupancy), 32'(m_occ));
    chk("full",      32'(full), 32'(m_occ == DEPTH));
    chk("can_count", 32'(can_count), 32'(cc));
    chk("done",      32'(done), 32'(m_phase == 2 && m_occ == 0));
    chk("err_underflow", 32'(err_underflow), 32'(m_err));
    chk("state",     32'(state_dbg), 32'(m_phase));

    if (wr) exp_q.push_back(ADDR_W'(m_ptr));
    if (wr_en === 1'b1) begin
      if (exp_q.size() > 0) chk("sb_addr", 32'(wr_addr), 32'(exp_q.pop_front()));
      else chk("sb_unexpected_write", 32'(1), 32'(0));
    end
    if (done === 1'b1) dut_done_cnt++;

    @(posedge clk);
    if (rst || inner_rst) begin
      m_phase = 0; m_occ = 0; m_ptr = 0; m_err = 0;
    end else begin
      rel = rd_release && (m_occ > 0);
      if (rd_release && m_occ == 0) m_err = 1;
      if (m_phase == 2 && m_occ == 0) begin
        m_phase = 0;
        m_done_cnt++;
      end else if (m_phase == 0 && start) begin
        m_phase = 1;
      end else if (m_phase == 1 && wr && bus.in_last) begin
        m_phase = 2;
      end
      m_occ = m_occ + int'(wr) - int'(rel);
      if (wr) m_ptr = (m_ptr + 1) % DEPTH;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic l, input logic r);
    bus.in_valid = v;
    bus.in_last  = l;
    rd_release   = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_asserts = 0; n_fails = 0;
    m_phase = 0; m_occ = 0; m_ptr = 0; m_err = 0;
    m_done_cnt = 0; dut_done_cnt = 0;
    rst = 1'b1; inner_rst = 1'b0; start = 1'b0;
    drive(1'b0, 1'b0, 1'b0);

    // 1. reset for two cycles, then start
    @(posedge clk);
    @(negedge clk);
    step_cycle();
    rst = 1'b0;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    chk("t1_state_write", 32'(state_dbg), 32'(WRITE));

    // 2. fill to full with 17 offered words, no release
    drive(1'b1, 1'b0, 1'b0);
    repeat (17) step_cycle();
    chk("t2_full", 32'(full), 32'(1));
    chk("t2_occ16", 32'(occupancy), 32'(16));

    // 3. full plus release every cycle; pointer wraps through 0
    drive(1'b1, 1'b0, 1'b1);
    repeat (20) step_cycle();
    repeat (60) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      step_cycle();
    end

    // 4. tail flush: new frame, last on the 5th word
    drive(1'b0, 1'b0, 1'b0);
    inner_rst = 1'b1;
    step_cycle();
    inner_rst = 1'b0;
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'(i == 4), 1'b0);
      step_cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("t4_flush", 32'(state_dbg), 32'(FLUSH));
    chk("t4_can_count", 32'(can_count), 32'(1));
    repeat (14) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step_cycle();
    end
    while (m_phase == 2 && m_occ > 0) begin
      drive(1'b0, 1'b0, 1'b1);
      step_cycle();
    end
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step_cycle();
    chk("t4_done_once", 32'(dut_done_cnt), 32'(1));

    // 5. underflow in idle, sticky until reset
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    step_cycle();
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) step_cycle();
    chk("t5_err_sticky", 32'(err_underflow), 32'(1));
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;

    // 6. mid-frame clear at occupancy 7: no done pulse
    start = 1'b1;
    step_cycle();
    start = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    repeat (7) step_cycle();
    chk("t6_occ7", 32'(occupancy), 32'(7));
    chk("t6_ptr7", 32'(wr_addr), 32'(7));
    drive(1'b0, 1'b0, 1'b0);
    inner_rst = 1'b1;
    step_cycle();
    inner_rst = 1'b0;
    repeat (3) step_cycle();
    chk("t6_no_done", 32'(dut_done_cnt), 32'(1));

    // 7. random frames
    repeat (400) begin
      start     = (m_phase == 0) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 7) == 0);
      inner_rst = 1'($urandom_range(0, 99) == 0);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
            1'($urandom_range(0, 1)));
      step_cycle();
    end
    start = 1'b0; inner_rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    step_cycle();

    chk("done_count", 32'(dut_done_cnt), 32'(m_done_cnt));
    chk("sb_empty", 32'(exp_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
